seq_divider: RTL and testbench

- Sequential radix-2 restoring divider, the inverse of the team's booth multiplier.
- Divides a 2W-bit unsigned dividend by a W-bit unsigned divisor, producing a W-bit quotient and a W-bit remainder.
- Uses a start/busy/done handshake and resolves one quotient bit per clock.
- Sits beside booth in the arithmetic datapath and shares its operand widths (4-bit operands, 8-bit wide value).

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Sliced down to WIDTH at the point of use.
  localparam logic [63:0] OVF_QUOT_ALL = '1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_diff[WIDTH];
  // The partial remainder stays below the divisor, so the restored value fits in WIDTH bits.
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, 2W/W -> W quotient + W remainder, one bit per clock.
// Optional SEQ_DIVIDER_BYPASS_EN: divide-by-one with a zero upper half completes without RUN.
import div_pkg::*;

module seq_divider #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  div_state_t       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_ovf;

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_ovf_det;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_next;

  assign w_hi      = dividend[2*WIDTH-1:WIDTH];
  assign w_lo      = dividend[WIDTH-1:0];
  assign w_ovf_det = (divisor == '0) || (w_hi >= divisor);
  assign w_q_next  = {r_q[WIDTH-2:0], w_qbit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_q[WIDTH-1]),
    .i_divisor (r_div),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_ovf_det) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= OVF_QUOT_ALL[WIDTH-1:0];
              r_remo  <= w_lo;
              r_ovf   <= 1'b1;
`ifdef SEQ_DIVIDER_BYPASS_EN
            end else if ((divisor == WIDTH'(1)) && (w_hi == '0)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= w_lo;
              r_remo  <= '0;
              r_ovf   <= 1'b0;
`endif
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_rem   <= w_hi;
              r_q     <= w_lo;
              r_div   <= divisor;
              r_count <= '0;
              r_ovf   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_rem_next;
          r_q     <= w_q_next;
          r_count <= r_count + CW'(1);
          if (r_count == LAST_CNT) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_next;
            r_remo  <= w_rem_next;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: arithmetic reference model, randomized and directed operations.
module tb_seq_divider;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned q;
    int unsigned r;
    int unsigned ov;
    int          lat;
    int          nbusy;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(input int unsigned dvd, input int unsigned dvs);
    exp_t e;
    int unsigned hi;
    int unsigned lo;
    hi = dvd / (1 << W);
    lo = dvd % (1 << W);
    if (dvs == 0 || hi >= dvs) begin
      e.q = (1 << W) - 1; e.r = lo; e.ov = 1; e.lat = 1; e.nbusy = 0;
    end else begin
      e.q = dvd / dvs; e.r = dvd % dvs; e.ov = 0; e.lat = W + 1; e.nbusy = W;
`ifdef SEQ_DIVIDER_BYPASS_EN
      if (dvs == 1) begin e.lat = 1; e.nbusy = 0; end
`endif
    end
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy && done) chk("busy_with_done", 1, 0);
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("ovf", ovf, e.ov);
          chk("latency", cyc - e.acc_cyc + 1, e.lat);
          chk("busy_cycles", busy_cnt, e.nbusy);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input int junk);
    exp_t e;
    @(negedge clk);
    #1;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e = model(dvd, dvs);
    e.acc_cyc = cyc + 1;
    last_exp = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (junk > 0) begin
      dividend = 8'd50;
      divisor  = 4'd3;
      repeat (junk) @(posedge clk);
      #1;
    end
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    wait_empty();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_q"}, quotient, 0);
    chk({tag, "_r"}, remainder, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] dv;
    // Reset with start held high: reset must win.
    reset = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 4'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    #1;
    start = 1'b0;
    reset = 1'b0;

    do_op(8'd100, 4'd7, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_q", quotient, last_exp.q);
      chk("hold_r", remainder, last_exp.r);
      chk("hold_done_low", done, 0);
    end
    do_op(8'd239, 4'd15, 0);
    do_op(8'd119, 4'd8, 0);
    do_op(8'd200, 4'd5, 0);
    do_op(8'd9, 4'd0, 0);
    do_op(8'd11, 4'd1, 0);
    do_op(8'd100, 4'd7, 4);
    do_op(8'd50, 4'd3, 0);
    do_op(8'd0, 4'd1, 0);
    do_op(8'd255, 4'd15, 0);

    // Abort during the second RUN cycle.
    @(negedge clk);
    #1;
    dividend = 8'd100; divisor = 4'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("run_busy_before_abort", busy, 1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("abort");
    #1;
    reset = 1'b0;
    do_op(8'd100, 4'd7, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_op(8'($urandom), 4'($urandom), 0);
      end else begin
        dv = 4'($urandom_range(1, 15));
        hi = 4'($urandom_range(0, int'(dv) - 1));
        lo = 4'($urandom);
        do_op({hi, lo}, dv, $urandom_range(0, 1) * 3);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
